// File: rtl/wb_csr_unit_pkg.sv
// wb_csr_unit_pkg
//   Shared constants for the writeback / CSR slice: CSR addresses,
//   mem_to_reg encodings for the GPR write mux, and mstatus bit positions.
//   Optional counter support is selected in wb_csr_unit by the
//   WB_CSR_COUNTERS_EN macro.
package wb_csr_unit_pkg;

  localparam int XLEN   = 64;
  localparam int CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL    = 12'h343;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MINSTRET = 12'hB02;
  localparam logic [CSR_AW-1:0] CSR_CYCLE    = 12'hC00;
  localparam logic [CSR_AW-1:0] CSR_INSTRET  = 12'hC02;

  typedef enum logic [2:0] {
    M2R_ALU = 3'd0,
    M2R_MEM = 3'd1,
    M2R_PC4 = 3'd2,
    M2R_IMM = 3'd3,
    M2R_CSR = 3'd4
  } mem_to_reg_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Only MIE and MPIE are stored; every other mstatus bit reads as 0.
  localparam logic [XLEN-1:0] MSTATUS_WMASK =
    (64'd1 << MSTATUS_MIE) | (64'd1 << MSTATUS_MPIE);

  // mtvec and mepc hold word-aligned addresses.
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
    return {v[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/wb_csr_unit_csr_counter64.sv
// csr_counter64
//   64-bit free-running counter with synchronous load. load wins over inc.
//   Wraps from 2^64-1 to 0.
// Ports:
//   clk, rst     clock, synchronous active-high reset (count -> 0)
//   inc          advance by one this cycle
//   load         replace the count with load_value this cycle
//   load_value   value to load
//   count        current count
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  logic [63:0] load_value,
  output logic [63:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/wb_csr_unit.sv
// wb_csr_unit
//   Writeback-stage consumer of the MEM/WB register. Drives the GPR write
//   port and owns the machine-mode CSR file (trap entry, mret, CSR writes,
//   optional mcycle/minstret counters).
// Configuration:
//   WB_CSR_COUNTERS_EN  when defined, builds mcycle/minstret (and the
//                       read-only cycle/instret shadows). Otherwise those
//                       addresses are unimplemented.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   *_WB                     WB-stage fields from RegMEMWB
//   retire_WB                WB slot holds a real instruction
//   trap_valid/cause/pc/tval trap entry request
//   mret_valid               return from trap
//   reg_we/waddr/wdata       GPR write port (combinational)
//   csr_raddr/rdata/illegal  CSR read port (combinational, write-first)
//   mtvec_out, mepc_out      redirect targets for fetch
//   mie_global               mstatus.MIE
module wb_csr_unit
  import wb_csr_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_WB,
  input  logic [63:0] imm_WB,
  input  logic [63:0] data_in_WB,
  input  logic [63:0] alu_result_WB,
  input  logic [63:0] csr_write_data_WB,
  input  logic [63:0] csr_read_data_WB,
  input  logic [4:0]  rd_WB,
  input  logic        reg_write_WB,
  input  logic [2:0]  mem_to_reg_WB,
  input  logic        csr_write_WB,
  input  logic        csr_write_src_WB,
  input  logic [11:0] csr_rd_WB,
  input  logic        retire_WB,
  input  logic        trap_valid,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_tval,
  input  logic        mret_valid,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [63:0] reg_wdata,
  input  logic [11:0] csr_raddr,
  output logic [63:0] csr_rdata,
  output logic        csr_illegal,
  output logic [63:0] mtvec_out,
  output logic [63:0] mepc_out,
  output logic        mie_global
);

  // ---------------- GPR write port ----------------
  always_comb begin
    reg_wdata = '0;
    case (mem_to_reg_WB)
      M2R_ALU: reg_wdata = alu_result_WB;
      M2R_MEM: reg_wdata = data_in_WB;
      M2R_PC4: reg_wdata = pc_WB + 64'd4;
      M2R_IMM: reg_wdata = imm_WB;
      M2R_CSR: reg_wdata = csr_read_data_WB;
      default: reg_wdata = '0;
    endcase
  end

  assign reg_we    = reg_write_WB && (rd_WB != 5'd0);
  assign reg_waddr = rd_WB;

  // ---------------- CSR state ----------------
  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [63:0] mie_q;
  logic [63:0] mtvec_q;
  logic [63:0] mscratch_q;
  logic [63:0] mepc_q;
  logic [63:0] mcause_q;
  logic [63:0] mtval_q;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [63:0] csr_wval;
  logic [63:0] wr_value;
  logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch;
  logic        wr_mepc, wr_mcause, wr_mtval, wr_mcycle, wr_minstret;
  logic        wr_any;

  assign csr_wval = csr_write_src_WB ? alu_result_WB : csr_write_data_WB;

  // Per-CSR write enables. A write is lost when trap or mret updates the
  // same CSR in this cycle; writes to unrelated CSRs still land.
  always_comb begin
    wr_mstatus  = 1'b0;
    wr_mie      = 1'b0;
    wr_mtvec    = 1'b0;
    wr_mscratch = 1'b0;
    wr_mepc     = 1'b0;
    wr_mcause   = 1'b0;
    wr_mtval    = 1'b0;
    wr_mcycle   = 1'b0;
    wr_minstret = 1'b0;
    if (csr_write_WB && !rst) begin
      case (csr_rd_WB)
        CSR_MSTATUS:  wr_mstatus  = !trap_valid && !mret_valid;
        CSR_MIE:      wr_mie      = 1'b1;
        CSR_MTVEC:    wr_mtvec    = 1'b1;
        CSR_MSCRATCH: wr_mscratch = 1'b1;
        CSR_MEPC:     wr_mepc     = !trap_valid;
        CSR_MCAUSE:   wr_mcause   = !trap_valid;
        CSR_MTVAL:    wr_mtval    = !trap_valid;
`ifdef WB_CSR_COUNTERS_EN
        CSR_MCYCLE:   wr_mcycle   = 1'b1;
        CSR_MINSTRET: wr_minstret = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign wr_any = wr_mstatus | wr_mie | wr_mtvec | wr_mscratch | wr_mepc |
                  wr_mcause | wr_mtval | wr_mcycle | wr_minstret;

  // Value as it will be stored, used both for commit and for the bypass.
  always_comb begin
    wr_value = csr_wval;
    case (csr_rd_WB)
      CSR_MSTATUS:         wr_value = csr_wval & MSTATUS_WMASK;
      CSR_MTVEC, CSR_MEPC: wr_value = align4(csr_wval);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      if (wr_mie)      mie_q      <= wr_value;
      if (wr_mtvec)    mtvec_q    <= wr_value;
      if (wr_mscratch) mscratch_q <= wr_value;
      if (wr_mepc)     mepc_q     <= wr_value;
      if (wr_mcause)   mcause_q   <= wr_value;
      if (wr_mtval)    mtval_q    <= wr_value;

      if (trap_valid) begin
        mepc_q         <= align4(trap_pc);
        mcause_q       <= trap_cause;
        mtval_q        <= trap_tval;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret_valid) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (wr_mstatus) begin
        mstatus_mie_q  <= wr_value[MSTATUS_MIE];
        mstatus_mpie_q <= wr_value[MSTATUS_MPIE];
      end
    end
  end

  // ---------------- Counters ----------------
`ifdef WB_CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk        (clk),
    .rst        (rst),
    .inc        (1'b1),
    .load       (wr_mcycle),
    .load_value (wr_value),
    .count      (mcycle)
  );

  csr_counter64 u_minstret (
    .clk        (clk),
    .rst        (rst),
    .inc        (retire_WB),
    .load       (wr_minstret),
    .load_value (wr_value),
    .count      (minstret)
  );
`else
  assign mcycle   = '0;
  assign minstret = '0;
  logic unused_counters;
  assign unused_counters = ^{retire_WB, mcycle, minstret, wr_mcycle, wr_minstret};
`endif

  // ---------------- Read port ----------------
  logic [63:0] rd_value;

  always_comb begin
    rd_value    = '0;
    csr_illegal = 1'b0;
    case (csr_raddr)
      CSR_MSTATUS:  rd_value = ({63'd0, mstatus_mie_q}  << MSTATUS_MIE) |
                               ({63'd0, mstatus_mpie_q} << MSTATUS_MPIE);
      CSR_MIE:      rd_value = mie_q;
      CSR_MTVEC:    rd_value = mtvec_q;
      CSR_MSCRATCH: rd_value = mscratch_q;
      CSR_MEPC:     rd_value = mepc_q;
      CSR_MCAUSE:   rd_value = mcause_q;
      CSR_MTVAL:    rd_value = mtval_q;
`ifdef WB_CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_CYCLE:     rd_value = mcycle;
      CSR_MINSTRET, CSR_INSTRET: rd_value = minstret;
`endif
      default:      csr_illegal = 1'b1;
    endcase
  end

  // Write-first: a committing write to the same address is forwarded.
  assign csr_rdata = (wr_any && (csr_rd_WB == csr_raddr)) ? wr_value : rd_value;

  assign mtvec_out  = mtvec_q;
  assign mepc_out   = mepc_q;
  assign mie_global = mstatus_mie_q;

endmodule
